// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a two-digit history.
// Define KEYPAD_SYNC_EN to pass the row lines through a 2-flop synchronizer.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state;
  logic [SCAN_W-1:0] dwell;
  logic [DEB_W-1:0]  deb;
  logic [1:0]        col_q;
  logic [1:0]        row_q;
  logic [3:0]        rows_s;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q1 <= 4'b1111;
      sync_q2 <= 4'b1111;
    end else begin
      sync_q1 <= rows;
      sync_q2 <= sync_q1;
    end
  end

  assign rows_s = sync_q2;
`else
  assign rows_s = rows;
`endif

  // A single low row on the driven column; more than one is treated as ghosting.
  logic [3:0] row_low_c;
  logic       one_row_c;
  logic [1:0] row_idx_c;
  logic       row_hit_c;

  assign row_low_c = ~rows_s;
  assign one_row_c = (row_low_c != 4'd0) && ((row_low_c & (row_low_c - 4'd1)) == 4'd0);
  assign row_hit_c = ~rows_s[row_q];

  always_comb begin
    row_idx_c = 2'd0;
    case (row_low_c)
      4'b0010: row_idx_c = 2'd1;
      4'b0100: row_idx_c = 2'd2;
      4'b1000: row_idx_c = 2'd3;
      default: row_idx_c = 2'd0;
    endcase
  end

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Scan / debounce / hold / release sequencing; cols stays frozen outside SCAN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCAN;
      cols      <= 4'b1110;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      dwell     <= '0;
      deb       <= '0;
      digit_new <= 4'd0;
      digit_old <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == SCAN_W'(SCAN_CYCLES - 1)) begin
            if (one_row_c) begin
              row_q <= row_idx_c;
              deb   <= '0;
              state <= DEBOUNCE;
            end else begin
              cols  <= {cols[2:0], cols[3]};
              col_q <= col_q + 2'd1;
              dwell <= '0;
            end
          end else begin
            dwell <= dwell + SCAN_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!row_hit_c) begin
            dwell <= '0;
            state <= SCAN;
          end else if (deb == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            digit_old <= digit_new;
            digit_new <= key_code(row_q, col_q);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            deb <= deb + DEB_W'(1);
          end
        end
        HELD: begin
          if (!row_hit_c) begin
            deb   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (row_hit_c) begin
            state <= HELD;
          end else if (deb == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            key_held <= 1'b0;
            cols     <= {cols[2:0], cols[3]};
            col_q    <= col_q + 2'd1;
            dwell    <= '0;
            state    <= SCAN;
          end else begin
            deb <= deb + DEB_W'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
